// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, ALU ops, mux selects,
// command codes and the registered control-word layout.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXECR, S_EXECI, S_MULWAIT, S_ALUWB, S_BRANCH
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_MUL = 3'b010,
        ALU_ACM = 3'b011,
        ALU_AND = 3'b100,
        ALU_ORR = 3'b101,
        ALU_PRM = 3'b110
    } alu_op_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_8  = 2'b00;
    localparam logic [1:0] IMM_12 = 2'b01;
    localparam logic [1:0] IMM_24 = 2'b10;

    localparam logic [3:0] CMD_ADD = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0001;
    localparam logic [3:0] CMD_MUL = 4'b0010;
    localparam logic [3:0] CMD_CMP = 4'b0100;
    localparam logic [3:0] CMD_AND = 4'b1000;
    localparam logic [3:0] CMD_ORR = 4'b1001;
    localparam logic [3:0] CMD_PRM = 4'b1010;
    localparam logic [3:0] CMD_ACM = 4'b1011;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_w;
        logic       reg_w;
        logic [1:0] result_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] imm_src;
        logic [1:0] reg_src;
        alu_op_t    alu_ctrl;
        logic [1:0] flag_w;
        logic       busy;
    } ctrl_out_t;

    // FETCH enables (IRWrite/PCWrite) are not in the word; they are gated live by mem_ready.
    localparam ctrl_out_t FETCH_OUT = '{
        pc_write: 1'b0, adr_src: 1'b0, mem_w: 1'b0, reg_w: 1'b0,
        result_src: RES_ALU, alu_src_a: 1'b1, alu_src_b: SRCB_FOUR,
        imm_src: IMM_8, reg_src: 2'b00, alu_ctrl: ALU_ADD,
        flag_w: 2'b00, busy: 1'b0
    };

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bundle between instruction/cond logic, the controller and the datapath.
// master = controller side, slave = datapath side.
interface multicycle_controller_if;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       CondEx;
    logic       mem_ready;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemW;
    logic       IRWrite;
    logic       RegW;
    logic [1:0] ResultSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [1:0] RegSrc;
    logic [2:0] ALUControl;
    logic [1:0] FlagW;
    logic       busy;

    modport master (
        input  Op, Funct, Rd, CondEx, mem_ready,
        output PCWrite, AdrSrc, MemW, IRWrite, RegW, ResultSrc, ALUSrcA,
               ALUSrcB, ImmSrc, RegSrc, ALUControl, FlagW, busy
    );

    modport slave (
        output Op, Funct, Rd, CondEx, mem_ready,
        input  PCWrite, AdrSrc, MemW, IRWrite, RegW, ResultSrc, ALUSrcA,
               ALUSrcB, ImmSrc, RegSrc, ALUControl, FlagW, busy
    );
endinterface

// File: rtl/alu_decoder.sv
// Combinational data-processing decode: (cmd, S) -> ALU op, flag write enables, CMP/MUL class.
// Zero latency; no flow control.
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [3:0] cmd_i,
    input  logic       s_i,
    output alu_op_t    alu_ctrl_o,
    output logic [1:0] flag_w_o,
    output logic       is_cmp_o,
    output logic       is_mul_o,
    output logic       legal_o
);
    alu_op_t op;
    logic    cmp, mul, legal;

    always_comb begin
        op    = ALU_ADD;
        cmp   = 1'b0;
        mul   = 1'b0;
        legal = 1'b1;
        case (cmd_i)
            CMD_ADD: op = ALU_ADD;
            CMD_SUB: op = ALU_SUB;
            CMD_MUL: begin op = ALU_MUL; mul = 1'b1; end
            CMD_AND: op = ALU_AND;
            CMD_ORR: op = ALU_ORR;
            CMD_PRM: op = ALU_PRM;
            CMD_ACM: op = ALU_ACM;
            // CMP always carries S; with S clear this encoding is the plain ADD form.
            CMD_CMP: if (s_i) begin op = ALU_SUB; cmp = 1'b1; end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        flag_w_o = 2'b00;
        if (cmp)
            flag_w_o = 2'b11;
        else if (legal)
            flag_w_o = {s_i, s_i & ((op == ALU_ADD) | (op == ALU_SUB))};
    end

    assign alu_ctrl_o = op;
    assign is_cmp_o   = cmp;
    assign is_mul_o   = mul;
    assign legal_o    = legal;
endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing the shared multicycle datapath; control word registered from next state.
// Stalls in FETCH/MEMRD/MEMWR until mem_ready; MUL holds the ALU MUL_CYCLES extra cycles.
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    multicycle_controller_if.master bus
);
    localparam logic [3:0] MUL_LAST  = 4'(MUL_CYCLES);
    localparam bit         MUL_MULTI = (MUL_CYCLES != 0);

    state_t    state_q, state_d;
    logic [1:0] op_q;
    logic [5:0] funct_q;
    logic [3:0] rd_q;
    logic [3:0] cnt_q, cnt_d;
    ctrl_out_t out_q, out_d, out_vis;

    // In DECODE the next state's controls must see the fields being latched this cycle.
    logic       in_decode;
    logic [1:0] op_e;
    logic [5:0] funct_e;
    logic [3:0] rd_e;
    assign in_decode = (state_q == S_DECODE);
    assign op_e      = in_decode ? bus.Op    : op_q;
    assign funct_e   = in_decode ? bus.Funct : funct_q;
    assign rd_e      = in_decode ? bus.Rd    : rd_q;

    alu_op_t    dec_alu;
    logic [1:0] dec_flag;
    logic       dec_cmp, dec_mul, dec_legal;

    alu_decoder u_alu_dec (
        .cmd_i      (funct_e[4:1]),
        .s_i        (funct_e[0]),
        .alu_ctrl_o (dec_alu),
        .flag_w_o   (dec_flag),
        .is_cmp_o   (dec_cmp),
        .is_mul_o   (dec_mul),
        .legal_o    (dec_legal)
    );

    logic mul_stall, wb_ok, rd_pc;
    assign mul_stall = dec_mul & MUL_MULTI;
    assign wb_ok     = dec_legal & (op_e == OP_DP);
    assign rd_pc     = (rd_e == 4'd15);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                if (!bus.CondEx)
                    state_d = S_FETCH;
                else begin
                    case (bus.Op)
                        OP_MEM:  state_d = S_MEMADR;
                        OP_DP:   state_d = bus.Funct[5] ? S_EXECI : S_EXECR;
                        OP_BR:   state_d = S_BRANCH;
                        default: state_d = S_FETCH;
                    endcase
                end
            end
            S_MEMADR: state_d = funct_q[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (bus.mem_ready) state_d = S_MEMWB;
            S_MEMWR:  if (bus.mem_ready) state_d = S_FETCH;
            S_EXECR, S_EXECI: begin
                if (mul_stall) begin
                    state_d = S_MULWAIT;
                    cnt_d   = 4'd1;
                end else if (dec_cmp)
                    state_d = S_FETCH;
                else
                    state_d = S_ALUWB;
            end
            S_MULWAIT: begin
                if (cnt_q == MUL_LAST) begin
                    state_d = S_ALUWB;
                    cnt_d   = 4'd0;
                end else
                    cnt_d = cnt_q + 4'd1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        out_d      = '0;
        out_d.busy = (state_d != S_FETCH);
        case (state_d)
            S_FETCH: out_d = FETCH_OUT;
            S_DECODE: begin
                out_d.result_src = RES_ALU;
                out_d.alu_src_a  = 1'b1;
                out_d.alu_src_b  = SRCB_FOUR;
            end
            S_MEMADR: begin
                out_d.alu_src_b = SRCB_IMM;
                out_d.imm_src   = IMM_12;
            end
            S_MEMRD: out_d.adr_src = 1'b1;
            S_MEMWR: begin
                out_d.adr_src = 1'b1;
                out_d.reg_src = 2'b10;
                out_d.mem_w   = 1'b1;
            end
            S_MEMWB: begin
                out_d.result_src = RES_DATA;
                out_d.pc_write   = rd_pc;
                out_d.reg_w      = ~rd_pc;
            end
            S_EXECR, S_EXECI: begin
                out_d.alu_src_b = (state_d == S_EXECI) ? SRCB_IMM : SRCB_RD2;
                out_d.imm_src   = IMM_8;
                out_d.alu_ctrl  = dec_alu;
                out_d.flag_w    = mul_stall ? 2'b00 : dec_flag;
            end
            S_MULWAIT: begin
                out_d.alu_src_b = funct_e[5] ? SRCB_IMM : SRCB_RD2;
                out_d.imm_src   = IMM_8;
                out_d.alu_ctrl  = dec_alu;
                out_d.flag_w    = (cnt_d == MUL_LAST) ? dec_flag : 2'b00;
            end
            S_ALUWB: begin
                out_d.result_src = RES_ALUOUT;
                out_d.pc_write   = wb_ok & rd_pc;
                out_d.reg_w      = wb_ok & ~rd_pc;
            end
            S_BRANCH: begin
                out_d.reg_src    = 2'b01;
                out_d.alu_src_b  = SRCB_IMM;
                out_d.imm_src    = IMM_24;
                out_d.result_src = RES_ALU;
                out_d.pc_write   = 1'b1;
            end
            default: out_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            op_q    <= '0;
            funct_q <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            out_q   <= FETCH_OUT;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            if (in_decode) begin
                op_q    <= bus.Op;
                funct_q <= bus.Funct;
                rd_q    <= bus.Rd;
            end
        end
    end

    // Outputs are forced low for the whole reset so an aborted write cannot leak.
    logic fetch_go;
    assign out_vis  = rst_n ? out_q : '0;
    assign fetch_go = rst_n & (state_q == S_FETCH) & bus.mem_ready;

    assign bus.PCWrite    = out_vis.pc_write | fetch_go;
    assign bus.IRWrite    = fetch_go;
    assign bus.AdrSrc     = out_vis.adr_src;
    assign bus.MemW       = out_vis.mem_w;
    assign bus.RegW       = out_vis.reg_w;
    assign bus.ResultSrc  = out_vis.result_src;
    assign bus.ALUSrcA    = out_vis.alu_src_a;
    assign bus.ALUSrcB    = out_vis.alu_src_b;
    assign bus.ImmSrc     = out_vis.imm_src;
    assign bus.RegSrc     = out_vis.reg_src;
    assign bus.ALUControl = out_vis.alu_ctrl;
    assign bus.FlagW      = out_vis.flag_w;
    assign bus.busy       = out_vis.busy;
endmodule

// File: tb/tb_multicycle_controller.sv
// Per-cycle control-word vectors for each instruction class, plus reset-abort of a stalled store.
module tb_multicycle_controller;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multicycle_controller_if bus();

    multicycle_controller #(.MUL_CYCLES(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string      name;
        logic [1:0] op;
        logic [5:0] funct;
        logic [3:0] rd;
        logic       condex;
        logic       mr;
        logic [19:0] exp;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    logic [19:0] act;
    assign act = {bus.PCWrite, bus.AdrSrc, bus.MemW, bus.IRWrite, bus.RegW, bus.ResultSrc,
                  bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.RegSrc, bus.ALUControl,
                  bus.FlagW, bus.busy};

    function automatic logic [19:0] ex(input logic pcw, input logic adr, input logic memw,
                                       input logic irw, input logic regw, input logic [1:0] res,
                                       input logic srca, input logic [1:0] srcb,
                                       input logic [1:0] imm, input logic [1:0] regsrc,
                                       input logic [2:0] alu, input logic [1:0] fw,
                                       input logic busy);
        return {pcw, adr, memw, irw, regw, res, srca, srcb, imm, regsrc, alu, fw, busy};
    endfunction

    function automatic logic [19:0] exr(input logic [2:0] alu, input logic [1:0] fw);
        return ex(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, alu, fw, 1);
    endfunction

    function automatic logic [19:0] exi(input logic [2:0] alu, input logic [1:0] fw);
        return ex(0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 2'b00, alu, fw, 1);
    endfunction

    task automatic check(input string name, input logic [19:0] got, input logic [19:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    task automatic add(input string name, input logic [1:0] op, input logic [5:0] funct,
                       input logic [3:0] rd, input logic condex, input logic mr,
                       input logic [19:0] exp);
        vec_t v;
        v.name = name; v.op = op; v.funct = funct; v.rd = rd;
        v.condex = condex; v.mr = mr; v.exp = exp;
        vecs.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [19:0] F_RDY, F_WAIT, DEC, MADR, MRD, MWR, MWB_PC, WB_REG, WB_PC, BR;
        F_RDY  = ex(1, 0, 0, 1, 0, 2'b10, 1, 2'b10, 2'b00, 2'b00, 3'b000, 2'b00, 0);
        F_WAIT = ex(0, 0, 0, 0, 0, 2'b10, 1, 2'b10, 2'b00, 2'b00, 3'b000, 2'b00, 0);
        DEC    = ex(0, 0, 0, 0, 0, 2'b10, 1, 2'b10, 2'b00, 2'b00, 3'b000, 2'b00, 1);
        MADR   = ex(0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b01, 2'b00, 3'b000, 2'b00, 1);
        MRD    = ex(0, 1, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1);
        MWR    = ex(0, 1, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b10, 3'b000, 2'b00, 1);
        MWB_PC = ex(1, 0, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1);
        WB_REG = ex(0, 0, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1);
        WB_PC  = ex(1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1);
        BR     = ex(1, 0, 0, 0, 0, 2'b10, 0, 2'b01, 2'b10, 2'b01, 3'b000, 2'b00, 1);

        add("add_fetch", 2'b00, 6'b001000, 4'd1, 1, 1, F_RDY);
        add("add_dec",   2'b00, 6'b001000, 4'd1, 1, 1, DEC);
        add("add_ex",    2'b00, 6'b001000, 4'd1, 1, 1, exr(3'b000, 2'b00));
        add("add_wb",    2'b00, 6'b001000, 4'd1, 1, 1, WB_REG);
        add("ldr_fetch", 2'b01, 6'b011001, 4'd15, 1, 1, F_RDY);
        add("ldr_dec",   2'b01, 6'b011001, 4'd15, 1, 1, DEC);
        add("ldr_adr",   2'b01, 6'b011001, 4'd15, 1, 1, MADR);
        add("ldr_rd0",   2'b01, 6'b011001, 4'd15, 1, 0, MRD);
        add("ldr_rd1",   2'b01, 6'b011001, 4'd15, 1, 0, MRD);
        add("ldr_rd2",   2'b01, 6'b011001, 4'd15, 1, 1, MRD);
        add("ldr_wb_pc", 2'b01, 6'b011001, 4'd15, 1, 1, MWB_PC);
        add("mul_fetch", 2'b00, 6'b000101, 4'd2, 1, 1, F_RDY);
        add("mul_dec",   2'b00, 6'b000101, 4'd2, 1, 1, DEC);
        add("mul_ex",    2'b00, 6'b000101, 4'd2, 1, 1, exr(3'b010, 2'b00));
        add("mul_w1",    2'b00, 6'b000101, 4'd2, 1, 1, exr(3'b010, 2'b00));
        add("mul_w2",    2'b00, 6'b000101, 4'd2, 1, 1, exr(3'b010, 2'b00));
        add("mul_w3",    2'b00, 6'b000101, 4'd2, 1, 1, exr(3'b010, 2'b10));
        add("mul_wb",    2'b00, 6'b000101, 4'd2, 1, 1, WB_REG);
        add("cmp_fetch", 2'b00, 6'b001001, 4'd0, 1, 1, F_RDY);
        add("cmp_dec",   2'b00, 6'b001001, 4'd0, 1, 1, DEC);
        add("cmp_ex",    2'b00, 6'b001001, 4'd0, 1, 1, exr(3'b001, 2'b11));
        add("bnt_fetch", 2'b10, 6'b000000, 4'd0, 0, 1, F_RDY);
        add("bnt_dec",   2'b10, 6'b000000, 4'd0, 0, 1, DEC);
        add("b_fetch",   2'b10, 6'b000000, 4'd0, 1, 1, F_RDY);
        add("b_dec",     2'b10, 6'b000000, 4'd0, 1, 1, DEC);
        add("b_branch",  2'b10, 6'b000000, 4'd0, 1, 1, BR);
        add("orri_fetch", 2'b00, 6'b110011, 4'd4, 1, 1, F_RDY);
        add("orri_dec",  2'b00, 6'b110011, 4'd4, 1, 1, DEC);
        add("orri_ex",   2'b00, 6'b110011, 4'd4, 1, 1, exi(3'b101, 2'b10));
        add("orri_wb",   2'b00, 6'b110011, 4'd4, 1, 1, WB_REG);
        add("ill_fetch", 2'b11, 6'b000000, 4'd5, 1, 1, F_RDY);
        add("ill_dec",   2'b11, 6'b000000, 4'd5, 1, 1, DEC);
        add("addpc_fetch", 2'b00, 6'b000000, 4'd15, 1, 1, F_RDY);
        add("addpc_dec", 2'b00, 6'b000000, 4'd15, 1, 1, DEC);
        add("addpc_ex",  2'b00, 6'b000000, 4'd15, 1, 1, exr(3'b000, 2'b00));
        add("addpc_wb",  2'b00, 6'b000000, 4'd15, 1, 1, WB_PC);
        add("str_fwait", 2'b01, 6'b010000, 4'd3, 1, 0, F_WAIT);
        add("str_fetch", 2'b01, 6'b010000, 4'd3, 1, 1, F_RDY);
        add("str_dec",   2'b01, 6'b010000, 4'd3, 1, 1, DEC);
        add("str_adr",   2'b01, 6'b010000, 4'd3, 1, 1, MADR);
        add("str_wr0",   2'b01, 6'b010000, 4'd3, 1, 0, MWR);
        add("str_wr1",   2'b01, 6'b010000, 4'd3, 1, 1, MWR);
        add("str2_fetch", 2'b01, 6'b010000, 4'd3, 1, 1, F_RDY);
        add("str2_dec",  2'b01, 6'b010000, 4'd3, 1, 1, DEC);
        add("str2_adr",  2'b01, 6'b010000, 4'd3, 1, 1, MADR);
        add("str2_wr",   2'b01, 6'b010000, 4'd3, 1, 0, MWR);

        rst_n = 1'b0;
        bus.Op = 2'b00; bus.Funct = 6'b000000; bus.Rd = 4'd0;
        bus.CondEx = 1'b1; bus.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outs", act, 20'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            bus.Op        = vecs[i].op;
            bus.Funct     = vecs[i].funct;
            bus.Rd        = vecs[i].rd;
            bus.CondEx    = vecs[i].condex;
            bus.mem_ready = vecs[i].mr;
            sb.push_back(vecs[i]);
            @(negedge clk);
            begin
                vec_t e;
                e = sb.pop_front();
                check(e.name, act, e.exp);
            end
            @(posedge clk); #1;
        end

        // Store still stalled in MEMWR: reset must drop MemW immediately.
        check("memw_held", {19'd0, bus.MemW}, 20'd1);
        rst_n = 1'b0;
        #1;
        check("memw_drop", {19'd0, bus.MemW}, 20'd0);
        check("rst_mid_outs", act, 20'd0);
        @(posedge clk); #1;
        check("rst_hold_outs", act, 20'd0);
        bus.Op = 2'b00; bus.Funct = 6'b001000; bus.Rd = 4'd1;
        bus.CondEx = 1'b1; bus.mem_ready = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_fetch", act, F_RDY);
        @(posedge clk); #1;
        @(negedge clk);
        check("post_rst_dec", act, DEC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
